memory_unit: RTL and testbench

MEMORY_UNIT -- requirements
Module: memory_unit

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_array.sv | 32 +++
 rtl/memory_unit.sv | 145 ++++++++++++++
 tb/tb_memory_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory unit: funct3 codes, FSM states
// and the access legality check used at request capture.
`default_nettype none

package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Invalid width code or misaligned lane; range is checked by the caller.
  function automatic logic access_bad(input logic is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic bad_code;
    logic misaligned;
    if (is_store) begin
      bad_code = (f3 != F3_SB) && (f3 != F3_SH) && (f3 != F3_SW);
    end else begin
      bad_code = (f3 != F3_LB) && (f3 != F3_LH) && (f3 != F3_LW) &&
                 (f3 != F3_LBU) && (f3 != F3_LHU);
    end
    misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                 ((f3[1:0] == 2'b10) && (lane != 2'b00));
    return bad_code || misaligned;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 32-bit words with byte enables and 1-cycle read.
`default_nettype none

module mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/memory_unit.sv
// RV32I load/store unit: captures one request, accesses mem_array, and returns
// a registered, width-extended result with done/err two cycles after acceptance.
`default_nettype none

module memory_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t state, state_next;

  logic          cap_we;
  logic [2:0]    cap_f3;
  logic [1:0]    cap_lane;
  logic [AW-1:0] cap_word;
  logic [31:0]   cap_wdata;
  logic          cap_bad;

  logic          out_of_range;
  logic          accept;
  logic          ram_en;
  logic          ram_we;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic [31:0]   ram_q;
  logic [31:0]   ld_shift;
  logic [31:0]   ld_val;

  assign out_of_range = ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
  assign accept       = (state == ST_IDLE) && req;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= we;
      cap_f3    <= funct3;
      cap_lane  <= addr[1:0];
      cap_word  <= addr[AW+1:2];
      cap_wdata <= wdata;
      cap_bad   <= out_of_range || access_bad(we, funct3, addr[1:0]);
    end
  end

  // Reset in the ACCESS cycle must not let the write land.
  assign ram_en = (state == ST_ACCESS) && !cap_bad && !rst;
  assign ram_we = ram_en && cap_we;

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    case (cap_f3)
      F3_SB: begin
        st_be   = 4'b0001 << cap_lane;
        st_data = {4{cap_wdata[7:0]}};
      end
      F3_SH: begin
        st_be   = cap_lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{cap_wdata[15:0]}};
      end
      F3_SW: begin
        st_be   = 4'b1111;
        st_data = cap_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = 32'h0;
      end
    endcase
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (st_be),
    .addr (cap_word),
    .wdata(st_data),
    .rdata(ram_q)
  );

  assign ld_shift = ram_q >> {cap_lane, 3'b000};

  always_comb begin
    ld_val = 32'h0;
    case (cap_f3)
      F3_LB:   ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_LH:   ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_LW:   ld_val = ram_q;
      F3_LBU:  ld_val = {24'h0, ld_shift[7:0]};
      F3_LHU:  ld_val = {16'h0, ld_shift[15:0]};
      default: ld_val = 32'h0;
    endcase
  end

  // Result registers update as RESP is left; stores keep the previous rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      done <= (state == ST_RESP);
      err  <= (state == ST_RESP) && cap_bad;
      if ((state == ST_RESP) && (cap_bad || !cap_we)) begin
        rdata <= cap_bad ? 32'h0 : ld_val;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_unit.sv
// Directed and randomized checks of memory_unit against a byte-array model.
`default_nettype none

module tb_memory_unit;

  localparam int DEPTH = 64;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [7:0]  model_mem [NBYTES];
  logic [31:0] exp_rdata = 32'h0;

  memory_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .funct3(funct3),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic model_bad(input logic w, input logic [2:0] f, input logic [31:0] a);
    logic bad;
    bad = 1'b0;
    if (w) bad = !(f == 3'd0 || f == 3'd1 || f == 3'd2);
    else   bad = !(f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) bad = 1'b1;
    if (f == 3'd2 && (a % 4 != 0)) bad = 1'b1;
    if ((a / 4) >= DEPTH) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_word(input int a);
    return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
  endfunction

  // One complete access: drive, disturb req while busy, check timing and result.
  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    logic bad;
    int ia;
    bad = model_bad(w, f, a);
    ia = int'(a);
    if (bad) begin
      exp_rdata = 32'h0;
    end else if (w) begin
      model_mem[ia] = d[7:0];
      if (f != 3'd0) model_mem[ia+1] = d[15:8];
      if (f == 3'd2) begin
        model_mem[ia+2] = d[23:16];
        model_mem[ia+3] = d[31:24];
      end
    end else begin
      case (f)
        3'd0: exp_rdata = {{24{model_mem[ia][7]}}, model_mem[ia]};
        3'd1: exp_rdata = {{16{model_mem[ia+1][7]}}, model_mem[ia+1], model_mem[ia]};
        3'd2: exp_rdata = model_word(ia);
        3'd4: exp_rdata = {24'h0, model_mem[ia]};
        default: exp_rdata = {16'h0, model_mem[ia+1], model_mem[ia]};
      endcase
    end
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    chk({tag, ".busy_acc"}, 32'(busy), 32'd1);
    chk({tag, ".done_acc"}, 32'(done), 32'd0);
    req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
    funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    @(posedge clk); #1;
    chk({tag, ".busy_resp"}, 32'(busy), 32'd1);
    chk({tag, ".done_resp"}, 32'(done), 32'd0);
    req = 1'($urandom_range(0, 1)); addr = $urandom;
    @(posedge clk); #1;
    req = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'(bad));
    chk({tag, ".rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.rdata", rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) access(1'b1, 3'd2, 32'(4 * i), $urandom, "init");

    access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
    access(1'b0, 3'd2, 32'h10, 32'h0, "lw10");
    chk("lw10.value", rdata, 32'hDEADBEEF);
    access(1'b1, 3'd0, 32'h11, 32'h000000AA, "sb11");
    access(1'b0, 3'd2, 32'h10, 32'h0, "lw10_merged");
    chk("lw10_merged.value", rdata, 32'hDEADAAEF);
    access(1'b0, 3'd0, 32'h11, 32'h0, "lb11");
    chk("lb11.value", rdata, 32'hFFFFFFAA);
    access(1'b0, 3'd4, 32'h11, 32'h0, "lbu11");
    chk("lbu11.value", rdata, 32'h000000AA);
    access(1'b0, 3'd1, 32'h13, 32'h0, "lh13_misalign");
    access(1'b1, 3'd2, 32'h12, 32'h55555555, "sw12_misalign");
    access(1'b0, 3'd2, 32'h10, 32'h0, "lw10_after_err");
    chk("lw10_after_err.value", rdata, 32'hDEADAAEF);
    access(1'b0, 3'd2, 32'(4 * DEPTH), 32'h0, "lw_range");
    access(1'b0, 3'd3, 32'h10, 32'h0, "ld_f3_011");
    access(1'b1, 3'd3, 32'h10, 32'h0, "st_f3_011");
    access(1'b1, 3'd1, 32'h16, 32'h0000C0DE, "sh16");
    access(1'b0, 3'd1, 32'h16, 32'h0, "lh16");
    access(1'b0, 3'd5, 32'h16, 32'h0, "lhu16");

    // Continuous req: one acceptance every third edge.
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h10;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk("b2b.busy", 32'(busy), 32'((k % 3) != 2));
      chk("b2b.done", 32'(done), 32'((k % 3) == 2));
      if (k % 3 == 2) chk("b2b.rdata", rdata, 32'hDEADAAEF);
    end
    req = 1'b0;
    exp_rdata = 32'hDEADAAEF;

    // Reset during ACCESS suppresses the write and the done pulse.
    access(1'b0, 3'd2, 32'h20, 32'h0, "lw20_before");
    req = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_acc.busy", 32'(busy), 32'd0);
    chk("rst_acc.done", 32'(done), 32'd0);
    chk("rst_acc.rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_acc.done_late", 32'(done), 32'd0);
    access(1'b0, 3'd2, 32'h20, 32'h0, "lw20_after_rst");

    for (int n = 0; n < 250; n++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = $urandom | 32'h0001_0000;
      else if (r == 1) a = 32'($urandom_range(NBYTES, NBYTES + 64));
      else             a = 32'($urandom_range(0, NBYTES - 1));
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
